// File: rtl/mem_pkg.sv
// Shared types and helpers for the burst memory: access-size encodings,
// burst length decode, default base address and depth arithmetic.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_1  = 2'b00,
    SZ_4  = 2'b01,
    SZ_8  = 2'b10,
    SZ_16 = 2'b11
  } acc_size_e;

  localparam logic [31:0] DEFAULT_START_ADDR = 32'h8002_0000;

  function automatic logic [4:0] burst_len(input logic [1:0] sz);
    case (acc_size_e'(sz))
      SZ_1:    burst_len = 5'd1;
      SZ_4:    burst_len = 5'd4;
      SZ_8:    burst_len = 5'd8;
      default: burst_len = 5'd16;
    endcase
  endfunction

  function automatic int depth_words(input int bytes, input int dw);
    return bytes / (dw / 8);
  endfunction

endpackage

// File: rtl/burst_memory_if.sv
// Request/response bus between the fetch/load-store units and burst_memory.
interface burst_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [1:0]            access_size;
  logic                  rw;
  logic                  enable;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  addr_error;

  modport master (
    output address, data_in, access_size, rw, enable,
    input  busy, data_out, data_valid, addr_error
  );

  modport slave (
    input  address, data_in, access_size, rw, enable,
    output busy, data_out, data_valid, addr_error
  );
endinterface

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: one read or one write per cycle, registered read.
module sp_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      else      rdata_q     <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/burst_memory.sv
// Burst-capable word memory: accept/beat control, wrapping index generation
// and range check in front of a single-port RAM.
module burst_memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 1048576,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(DEFAULT_START_ADDR)
) (
  input  logic clock,
  input  logic reset,
  burst_memory_if.slave bus
);
  localparam int DEPTH_WORDS = depth_words(DEPTH_BYTES, DATA_WIDTH);
  localparam int IDX_W       = $clog2(DEPTH_WORDS);
  localparam int BYTE_SH     = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH_BYTES);

  logic [3:0]            rem_q, rem_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rw_q, rw_d, oor_q, oor_d;
  logic                  valid_q, valid_d, err_q, err_d, zero_q, zero_d;

  logic [ADDR_WIDTH-1:0] off;
  logic                  in_range, busy, beat_vld, beat_rd, beat_oor;
  logic [IDX_W-1:0]      idx0, beat_idx;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    off      = bus.address - START_ADDR;
    in_range = (bus.address >= START_ADDR) && (off < SPAN);
    idx0     = IDX_W'(off >> BYTE_SH);
    busy     = (rem_q != '0);
    // Beat 0 comes straight from the bus; later beats from the latched burst.
    beat_vld = busy | bus.enable;
    beat_idx = busy ? idx_q : idx0;
    beat_rd  = busy ? rw_q  : bus.rw;
    beat_oor = busy ? oor_q : !in_range;

    rem_d = rem_q;
    rw_d  = rw_q;
    oor_d = oor_q;
    if (busy) begin
      rem_d = rem_q - 4'd1;
    end else if (bus.enable) begin
      rem_d = 4'(burst_len(bus.access_size) - 5'd1);
      rw_d  = bus.rw;
      oor_d = !in_range;
    end
    // Index width equals log2(depth), so the increment wraps to word 0 naturally.
    idx_d   = beat_idx + IDX_W'(1);
    valid_d = beat_vld & beat_rd;
    err_d   = !busy & bus.enable & !in_range;
    zero_d  = (beat_vld & beat_rd) ? beat_oor : zero_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      oor_q   <= oor_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  // Out-of-range beats never touch the array; reads see zero via zero_q.
  sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clock),
    .en_i   (beat_vld & !reset & !beat_oor),
    .we_i   (!beat_rd),
    .addr_i (beat_idx),
    .wdata_i(bus.data_in),
    .rdata_o(ram_rdata)
  );

  assign bus.busy       = busy;
  assign bus.data_valid = valid_q;
  assign bus.addr_error = err_q;
  assign bus.data_out   = zero_q ? '0 : ram_rdata;
endmodule

// File: tb/tb_burst_memory.sv
// Random and directed bursts against a transaction-level array model of burst_memory.
module tb_burst_memory;
  import mem_pkg::*;

  localparam int          DW = 32;
  localparam int          AW = 32;
  localparam int          DB = 1024;
  localparam int          NW = DB / 4;
  localparam logic [31:0] SA = 32'h8002_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  burst_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_BYTES(DB),
    .START_ADDR (SA)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  logic [31:0] mem_m [NW];
  logic [31:0] wbuf  [16];
  logic [31:0] last_rd;
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int blen(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (1 << (int'(sz) + 1));
  endfunction

  task automatic rand_wbuf();
    for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
  endtask

  task automatic drive_junk();
    bus.enable      = 1'b1;
    bus.rw          = 1'($urandom);
    bus.access_size = 2'($urandom);
    bus.address     = $urandom;
  endtask

  // Issue one burst at the current negedge and check every beat after its edge.
  task automatic do_burst(input bit rd, input logic [1:0] sz, input logic [31:0] addr,
                          input bit junk);
    int          n    = blen(sz);
    longint      off  = longint'(addr) - longint'(SA);
    bit          inr  = (off >= 0) && (off < DB);
    int          idx0 = inr ? int'(off / 4) : 0;
    int          w;
    logic [31:0] exp;
    bus.enable      = 1'b1;
    bus.rw          = rd;
    bus.access_size = sz;
    bus.address     = addr;
    bus.data_in     = wbuf[0];
    for (int k = 0; k < n; k++) begin
      w   = (idx0 + k) % NW;
      exp = inr ? mem_m[w] : 32'h0;
      if (!rd && inr) mem_m[w] = wbuf[k];
      @(posedge clk); @(negedge clk);
      chk("busy",  32'(bus.busy),       32'(k < n - 1));
      chk("err",   32'(bus.addr_error), 32'(k == 0 && !inr));
      chk("valid", 32'(bus.data_valid), 32'(rd));
      if (rd) begin
        chk("rdata", bus.data_out, exp);
        last_rd = exp;
      end else begin
        chk("hold", bus.data_out, last_rd);
      end
      if (k < n - 1) begin
        if (junk) drive_junk();
        else      bus.enable = 1'b0;
        bus.data_in = wbuf[k + 1];
      end
    end
  endtask

  task automatic idle(input int n);
    bus.enable = 1'b0;
    repeat (n) begin
      @(posedge clk); @(negedge clk);
      chk("idle_busy",  32'(bus.busy),       32'h0);
      chk("idle_valid", 32'(bus.data_valid), 32'h0);
      chk("idle_err",   32'(bus.addr_error), 32'h0);
      chk("idle_hold",  bus.data_out,        last_rd);
    end
  endtask

  task automatic read_all();
    for (int b = 0; b < NW / 16; b++) do_burst(1'b1, 2'd3, SA + 32'(b * 64), 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    bus.enable = 1'b0; bus.rw = 1'b0; bus.access_size = 2'd0;
    bus.address = '0; bus.data_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy),       32'h0);
    chk("rst_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_dout",  bus.data_out,        32'h0);
    chk("rst_err",   32'(bus.addr_error), 32'h0);
    rst = 1'b0;
    last_rd = 32'h0;

    // Preload the whole array so every later read has a known value.
    for (int b = 0; b < NW / 16; b++) begin
      rand_wbuf();
      do_burst(1'b0, 2'd3, SA + 32'(b * 64), 1'b1);
    end
    idle(1);

    wbuf[0] = 32'h8FA4_0000;
    do_burst(1'b0, 2'd0, SA, 1'b0);
    do_burst(1'b1, 2'd0, SA, 1'b0);
    idle(2);

    for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
    do_burst(1'b0, 2'd1, SA + 32'h10, 1'b0);
    do_burst(1'b1, 2'd1, SA + 32'h10, 1'b0);

    do_burst(1'b1, 2'd3, SA + DB - 4, 1'b0);

    do_burst(1'b1, 2'd0, 32'h8000_0000, 1'b0);
    wbuf[0] = 32'hDEAD_BEEF;
    do_burst(1'b0, 2'd0, 32'h8000_0000, 1'b0);
    rand_wbuf();
    do_burst(1'b0, 2'd2, SA + DB, 1'b1);
    idle(1);
    read_all();

    rand_wbuf();
    do_burst(1'b0, 2'd2, SA + 32'h100, 1'b1);
    do_burst(1'b1, 2'd2, SA + 32'h100, 1'b0);
    idle(2);

    // Reset lands on the third beat of an 8-word write.
    rand_wbuf();
    bus.enable = 1'b1; bus.rw = 1'b0; bus.access_size = 2'd2;
    bus.address = SA; bus.data_in = wbuf[0];
    @(posedge clk); @(negedge clk);
    chk("mid_busy0", 32'(bus.busy), 32'h1);
    bus.enable = 1'b0; bus.data_in = wbuf[1];
    @(posedge clk); @(negedge clk);
    chk("mid_busy1", 32'(bus.busy), 32'h1);
    rst = 1'b1; bus.data_in = wbuf[2];
    @(posedge clk); @(negedge clk);
    chk("mid_busy",  32'(bus.busy),       32'h0);
    chk("mid_valid", 32'(bus.data_valid), 32'h0);
    chk("mid_dout",  bus.data_out,        32'h0);
    chk("mid_err",   32'(bus.addr_error), 32'h0);
    rst = 1'b0;
    mem_m[0] = wbuf[0];
    mem_m[1] = wbuf[1];
    last_rd  = 32'h0;
    idle(1);
    do_burst(1'b1, 2'd2, SA, 1'b0);

    repeat (300) begin
      logic [31:0] a;
      case ($urandom % 8)
        0:       a = SA - 32'(4 * (1 + $urandom % 16));
        1:       a = SA + DB + 32'($urandom % 64);
        default: a = SA + 32'($urandom % DB);
      endcase
      rand_wbuf();
      do_burst(1'($urandom), 2'($urandom), a, 1'($urandom));
      if ($urandom % 4 == 0) idle(1);
    end
    idle(1);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/burst_memory.md
# burst_memory

Parametrised successor to the single-word processor memory: a word-organised, synchronous instruction/data memory that adds multi-word bursts, a `busy` handshake, a read-valid strobe and address-range checking. It sits between the fetch/load-store units and backing storage at base `START_ADDR`. Program images are preloaded by writing, then read back or fetched.

## Interface
- `DATA_WIDTH`, 32: word width in bits; multiple of 8.
- `ADDR_WIDTH`, 32: byte-address width.
- `DEPTH_BYTES`, 1048576: memory size in bytes; power of two.
- `START_ADDR`, 32'h80020000: byte address of word 0.
- `clock`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `address`, in, ADDR_WIDTH: byte address of first beat; low log2(DATA_WIDTH/8) bits ignored.
- `data_in`, in, DATA_WIDTH: write data, one word per beat.
- `access_size`, in, 2: burst length; 00=1, 01=4, 10=8, 11=16 words.
- `rw`, in, 1: 0=write, 1=read.
- `enable`, in, 1: request.
- `busy`, out, 1: burst in progress; new requests ignored.
- `data_out`, out, DATA_WIDTH: registered read data.
- `data_valid`, out, 1: `data_out` holds a read beat this cycle.
- `addr_error`, out, 1: one-cycle pulse; accepted start address out of range.

## Operation
- Accept: rising edge with `enable`=1, `busy`=0, `reset`=0. Latch `rw`, burst length N, start index `idx0 = (address - START_ADDR) >> log2(DATA_WIDTH/8)`.
- In range: `START_ADDR <= address < START_ADDR + DEPTH_BYTES`. Out of range: `addr_error`=1 for one cycle. All N beats still occupy the interface, but writes are suppressed and reads return 0 with `data_valid`=1.
- Beat k uses index `(idx0 + k) mod DEPTH_WORDS`. A burst crossing the top wraps to word 0, with no error.
- Write: beat 0 writes `data_in` at the accept edge. Beat k writes `data_in` sampled at edge T0+k.
- Read: beat k registered into `data_out` at edge T0+k. `data_valid`=1 in the following cycle.
- Counter `remaining` is loaded with N-1 at accept and decremented at each following beat edge. `busy = (remaining != 0)`, decoded from the register.
- While `busy`=1, `enable`, `rw`, `access_size` and `address` are ignored. `data_in` is still sampled for write beats.
- States: IDLE (remaining=0) and BURST (remaining>0). IDLE→BURST on accept with N>1; BURST→IDLE when remaining reaches 0.
- `data_out` holds its last value when `data_valid`=0.

## Timing
- Reset values: `busy`=0, `data_valid`=0, `data_out`=0, `addr_error`=0, `remaining`=0. Memory contents are not cleared.
- Read latency: 1 cycle from accept edge to first valid beat. Beats follow on consecutive cycles.
- A burst of N occupies edges T0..T0+N-1. Next accept is possible at edge T0+N. Single-word accesses can be accepted every cycle.
- `reset` asserted mid-burst aborts the burst at that edge. Remaining writes are dropped and no further `data_valid` is produced. Reset has priority over accept.
- Read-after-write to the same word on the next accept returns the new data (write-first array).

## Structure
- Package `mem_pkg`:
  - access_size encodings;
  - burst length function (2 bits → 1/4/8/16);
  - default `START_ADDR`;
  - localparam helper for `DEPTH_WORDS = DEPTH_BYTES/(DATA_WIDTH/8)`.
- Sub-module `sp_ram`: single-port synchronous RAM, parameters DATA_WIDTH/DEPTH_WORDS, one read or one write per cycle, registered read. `burst_memory` holds only the control FSM, counter, index generation and range check.

## Test plan
- Single write then read: write 32'h8FA40000 at 32'h80020000; read same address one cycle later → `data_out`=32'h8FA40000, `data_valid` high 1 cycle, `busy` never high.
- 4-word write burst at 32'h80020010 with data 1,2,3,4 → `busy` high 3 cycles; 4-word read burst → 1,2,3,4 on consecutive cycles.
- 16-word read starting at last word (START_ADDR+DEPTH_BYTES-4) → beat 0 is top word, beats 1..15 are words 0..14, `addr_error`=0.
- Request at 32'h80000000 (below base), read size 00 → `addr_error` pulse, `data_out`=0 with `data_valid`=1; a write of 32'hDEADBEEF there leaves all words unchanged.
- `enable` with a new read held during an 8-beat write → ignored until `busy` falls; accepted at edge T0+8.
- `reset` at the 3rd beat of an 8-word write → `busy`=0 next cycle; words 0–1 written, words 2–7 unchanged; contents survive reset.
